// File: rtl/bus_drv_pkg.sv
`default_nettype none
// ============================================================================
// Package : bus_drv_pkg
// Brief   : Shared constants and types for the bus driver device ports.
// Rev     : 1.0  initial release
// ============================================================================
package bus_drv_pkg;

    localparam int         PKT_W    = 16;
    localparam logic [7:0] BCAST_ID = 8'hFF;

    typedef logic [PKT_W-1:0] pkt_t;

    // Bit positions inside err_flags: {rx_udf, rx_ovf, tx_udf, tx_ovf}
    typedef enum logic [1:0] {
        ERR_TX_OVF = 2'd0,
        ERR_TX_UDF = 2'd1,
        ERR_RX_OVF = 2'd2,
        ERR_RX_UDF = 2'd3
    } err_bit_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_fwft
// Brief   : First-word fall-through FIFO with per-cycle overflow/underflow strobes.
// Rev     : 1.0  initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [width-1:0]           din,
    input  logic                       rd,
    output logic [width-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       ovf,
    output logic                       udf
);
    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);
    localparam logic [PW-1:0] c_ptr_one  = PW'(1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [CW-1:0] c_cnt_full = CW'(depth);

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_cnt_full);
    // A full FIFO still accepts a write when the head leaves in the same cycle;
    // an empty FIFO ignores the read even if a write arrives alongside it.
    assign w_do_wr = wr && (!full || rd);
    assign w_do_rd = rd && !empty;
    assign ovf     = wr && full && !rd;
    assign udf     = rd && empty;
    assign dout    = empty ? '0 : r_mem[r_rd_ptr];
    assign count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_port_fifo.sv
`default_nettype none
// ============================================================================
// Module  : bus_port_fifo
// Brief   : Device-side TX/RX FIFO pair for one slot of the bus driver.
// Rev     : 1.0  initial release
// ============================================================================
module bus_port_fifo
    import bus_drv_pkg::*;
#(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dev_push,
    input  logic [width-1:0]           dev_din,
    output logic                       dev_full,
    output logic                       pndng,
    output logic [width-1:0]           D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [width-1:0]           D_push,
    input  logic                       dev_pop,
    output logic                       dev_rx_pndng,
    output logic [width-1:0]           dev_dout,
    output logic [$clog2(depth+1)-1:0] tx_count,
    output logic [$clog2(depth+1)-1:0] rx_count,
    output logic [3:0]                 err_flags
);
    logic       w_tx_empty;
    logic       w_tx_ovf;
    logic       w_tx_udf;
    logic       w_rx_empty;
    logic       w_unused_rx_full;
    logic       w_rx_ovf;
    logic       w_rx_udf;
    logic [3:0] w_err_evt;
    logic [3:0] r_err_flags;

    sync_fifo_fwft #(.width(width), .depth(depth)) u_tx (
        .clk   (clk),
        .reset (reset),
        .wr    (dev_push),
        .din   (dev_din),
        .rd    (pop),
        .dout  (D_pop),
        .empty (w_tx_empty),
        .full  (dev_full),
        .count (tx_count),
        .ovf   (w_tx_ovf),
        .udf   (w_tx_udf)
    );

    // The bus cannot be throttled, so RX full is never fed back.
    sync_fifo_fwft #(.width(width), .depth(depth)) u_rx (
        .clk   (clk),
        .reset (reset),
        .wr    (push),
        .din   (D_push),
        .rd    (dev_pop),
        .dout  (dev_dout),
        .empty (w_rx_empty),
        .full  (w_unused_rx_full),
        .count (rx_count),
        .ovf   (w_rx_ovf),
        .udf   (w_rx_udf)
    );

    assign pndng        = !w_tx_empty;
    assign dev_rx_pndng = !w_rx_empty;

    always_comb begin
        w_err_evt             = '0;
        w_err_evt[ERR_TX_OVF] = w_tx_ovf;
        w_err_evt[ERR_TX_UDF] = w_tx_udf;
        w_err_evt[ERR_RX_OVF] = w_rx_ovf;
        w_err_evt[ERR_RX_UDF] = w_rx_udf;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_flags <= '0;
        end else begin
            r_err_flags <= r_err_flags | w_err_evt;
        end
    end

    assign err_flags = r_err_flags;

endmodule
`default_nettype wire

// File: tb/tb_bus_port_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_port_fifo
// Brief   : Directed self-checking bench for bus_port_fifo (width 16, depth 8).
// Rev     : 1.0  initial release
// ============================================================================
module tb_bus_port_fifo;

    logic        clk;
    logic        reset;
    logic        dev_push;
    logic [15:0] dev_din;
    logic        dev_full;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        dev_pop;
    logic        dev_rx_pndng;
    logic [15:0] dev_dout;
    logic [3:0]  tx_count;
    logic [3:0]  rx_count;
    logic [3:0]  err_flags;

    int n_checks = 0;
    int n_errors = 0;

    bus_port_fifo #(.width(16), .depth(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .dev_push     (dev_push),
        .dev_din      (dev_din),
        .dev_full     (dev_full),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .dev_pop      (dev_pop),
        .dev_rx_pndng (dev_rx_pndng),
        .dev_dout     (dev_dout),
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .err_flags    (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous pulse placed mid-cycle, well away from any edge.
    task automatic pulse_reset();
        #1;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        dev_push = 1'b0;
        dev_din  = '0;
        pop      = 1'b0;
        push     = 1'b0;
        D_push   = '0;
        dev_pop  = 1'b0;
        tick();
        tick();
        chk("rst_pndng", {31'd0, pndng}, 32'd0);
        chk("rst_err", {28'd0, err_flags}, 32'd0);
        reset = 1'b1;

        // 1: reset mid-stream with three TX entries
        dev_push = 1'b1;
        dev_din  = 16'hAAA1; tick();
        dev_din  = 16'hAAA2; tick();
        dev_din  = 16'hAAA3; tick();
        dev_push = 1'b0;
        chk("t1_cnt3", {28'd0, tx_count}, 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_async_pndng", {31'd0, pndng}, 32'd0);
        chk("t1_async_cnt", {28'd0, tx_count}, 32'd0);
        chk("t1_async_err", {28'd0, err_flags}, 32'd0);
        chk("t1_async_dpop", {16'd0, D_pop}, 32'd0);
        chk("t1_async_full", {31'd0, dev_full}, 32'd0);
        tick();
        reset = 1'b1;
        pop   = 1'b1;
        tick();
        pop   = 1'b0;
        chk("t1_pop_pndng", {31'd0, pndng}, 32'd0);
        chk("t1_pop_dpop", {16'd0, D_pop}, 32'd0);
        chk("t1_pop_err", {28'd0, err_flags}, 32'h2);

        // 2: three pushes then three pops
        pulse_reset();
        tick();
        dev_push = 1'b1;
        dev_din  = 16'h0301; tick();
        chk("t2_pndng_1st", {31'd0, pndng}, 32'd1);
        chk("t2_dpop_1st", {16'd0, D_pop}, 32'h0301);
        dev_din  = 16'h0502; tick();
        dev_din  = 16'h0703; tick();
        dev_push = 1'b0;
        chk("t2_cnt3", {28'd0, tx_count}, 32'd3);
        chk("t2_head", {16'd0, D_pop}, 32'h0301);
        pop = 1'b1;
        tick();
        chk("t2_pop1", {16'd0, D_pop}, 32'h0502);
        tick();
        chk("t2_pop2", {16'd0, D_pop}, 32'h0703);
        tick();
        pop = 1'b0;
        chk("t2_pndng_end", {31'd0, pndng}, 32'd0);
        chk("t2_err", {28'd0, err_flags}, 32'd0);

        // 3: fill, overflow, push+pop while full
        pulse_reset();
        tick();
        dev_push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dev_din = 16'h1000 + 16'(i);
            tick();
        end
        chk("t3_full", {31'd0, dev_full}, 32'd1);
        chk("t3_cnt8", {28'd0, tx_count}, 32'd8);
        dev_din = 16'hDEAD;
        tick();
        chk("t3_ovf_err", {28'd0, err_flags}, 32'h1);
        chk("t3_ovf_cnt", {28'd0, tx_count}, 32'd8);
        chk("t3_ovf_head", {16'd0, D_pop}, 32'h1000);
        dev_din = 16'hBEEF;
        pop     = 1'b1;
        tick();
        dev_push = 1'b0;
        pop      = 1'b0;
        chk("t3_pp_cnt", {28'd0, tx_count}, 32'd8);
        chk("t3_pp_head", {16'd0, D_pop}, 32'h1001);
        pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_drain%0d", i), {16'd0, D_pop},
                (i < 7) ? (32'h1001 + 32'(i)) : 32'hBEEF);
            tick();
        end
        pop = 1'b0;
        chk("t3_drained", {31'd0, pndng}, 32'd0);
        chk("t3_err_end", {28'd0, err_flags}, 32'h1);

        // 4: wrap-around with 20 push/pop pairs
        pulse_reset();
        tick();
        for (int i = 0; i < 20; i++) begin
            dev_push = 1'b1;
            dev_din  = 16'(i);
            tick();
            dev_push = 1'b0;
            chk($sformatf("t4_data%0d", i), {16'd0, D_pop}, 32'(i));
            chk($sformatf("t4_cnt%0d", i), {28'd0, tx_count}, 32'd1);
            pop = 1'b1;
            tick();
            pop = 1'b0;
            chk($sformatf("t4_empty%0d", i), {28'd0, tx_count}, 32'd0);
        end
        chk("t4_err", {28'd0, err_flags}, 32'd0);

        // 5: RX path, ordering and overflow
        pulse_reset();
        tick();
        push   = 1'b1;
        D_push = 16'hFF55; tick();
        D_push = 16'h0244; tick();
        push   = 1'b0;
        chk("t5_pndng", {31'd0, dev_rx_pndng}, 32'd1);
        chk("t5_dout0", {16'd0, dev_dout}, 32'hFF55);
        chk("t5_cnt2", {28'd0, rx_count}, 32'd2);
        dev_pop = 1'b1;
        tick();
        chk("t5_dout1", {16'd0, dev_dout}, 32'h0244);
        chk("t5_cnt1", {28'd0, rx_count}, 32'd1);
        tick();
        dev_pop = 1'b0;
        chk("t5_cnt0", {28'd0, rx_count}, 32'd0);
        chk("t5_pndng0", {31'd0, dev_rx_pndng}, 32'd0);
        chk("t5_err0", {28'd0, err_flags}, 32'd0);
        push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            D_push = 16'h2000 + 16'(i);
            tick();
        end
        D_push = 16'h9999;
        tick();
        push = 1'b0;
        chk("t5_ovf_err", {28'd0, err_flags}, 32'h4);
        chk("t5_ovf_cnt", {28'd0, rx_count}, 32'd8);
        chk("t5_ovf_head", {16'd0, dev_dout}, 32'h2000);
        chk("t5_tx_idle", {28'd0, tx_count}, 32'd0);

        // 6: push and pop together on empty TX
        pulse_reset();
        tick();
        dev_push = 1'b1;
        pop      = 1'b1;
        dev_din  = 16'hABCD;
        tick();
        dev_push = 1'b0;
        pop      = 1'b0;
        chk("t6_cnt", {28'd0, tx_count}, 32'd1);
        chk("t6_err", {28'd0, err_flags}, 32'h2);
        chk("t6_dpop", {16'd0, D_pop}, 32'hABCD);
        chk("t6_pndng", {31'd0, pndng}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
